// File: rtl/arith_scheduler.sv
// arith_scheduler: two-requester 8-bit ALU front end sharing one 4-bit adder slice.
// Each accepted operation runs LO then HI nibble passes through the slice and is
// held in RESP until the consumer takes it.
module arith_scheduler #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [1:0] req0_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [1:0] req1_op,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_d,
    output logic       rsp_cout,
    output logic       busy
);

    localparam int unsigned DW  = 8;
    localparam int unsigned NW  = 4;
    localparam int unsigned OPW = 2;

    localparam logic [OPW-1:0] OP_ADD = 2'b00;
    localparam logic [OPW-1:0] OP_SUB = 2'b01;
    localparam logic [OPW-1:0] OP_INC = 2'b10;
    localparam logic [OPW-1:0] OP_DEC = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LO   = 2'b01,
        HI   = 2'b10,
        RESP = 2'b11
    } state_t;

    state_t          state;
    logic [OPW-1:0]  op_q;
    logic [DW-1:0]   a_q;
    logic [DW-1:0]   b_q;
    logic            carry_lo;
    logic            last_grant;

    logic            any_valid;
    logic            grant;
    logic [1:0]      sel;
    logic            cin_op;
    logic            cin;
    logic [NW-1:0]   nib_a;
    logic [NW-1:0]   nib_b;
    logic [NW-1:0]   y;
    logic [NW:0]     sum;

    // Arbitration: round-robin against last_grant, or req0 always first
    always_comb begin
        any_valid = req0_valid | req1_valid;
        grant     = ~req0_valid;
        if (RR_EN && req0_valid && req1_valid) begin
            grant = ~last_grant;
        end
        req0_ready = (state == IDLE) && any_valid && !grant;
        req1_ready = (state == IDLE) && any_valid && grant;
    end

    // Shared nibble slice: D = A + Y + CIN, operands steered by the current pass
    always_comb begin
        sel    = 2'b00;
        cin_op = 1'b0;
        case (op_q)
            OP_ADD: begin sel = 2'b00; cin_op = 1'b0; end
            OP_SUB: begin sel = 2'b01; cin_op = 1'b1; end
            OP_INC: begin sel = 2'b10; cin_op = 1'b1; end
            OP_DEC: begin sel = 2'b11; cin_op = 1'b0; end
            default: begin sel = 2'b00; cin_op = 1'b0; end
        endcase

        nib_a = (state == HI) ? a_q[DW-1:NW] : a_q[NW-1:0];
        nib_b = (state == HI) ? b_q[DW-1:NW] : b_q[NW-1:0];
        cin   = (state == HI) ? carry_lo : cin_op;

        case (sel)
            2'b00:   y = nib_b;
            2'b01:   y = ~nib_b;
            2'b10:   y = {NW{1'b0}};
            default: y = {NW{1'b1}};
        endcase

        sum = {1'b0, nib_a} + {1'b0, y} + (NW+1)'(cin);
    end

    // Sequencer: accept, low pass, high pass, hold response until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            carry_lo   <= 1'b0;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_d      <= '0;
            rsp_cout   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        op_q       <= grant ? req1_op : req0_op;
                        a_q        <= grant ? req1_a  : req0_a;
                        b_q        <= grant ? req1_b  : req0_b;
                        rsp_id     <= grant;
                        last_grant <= grant;
                        busy       <= 1'b1;
                        state      <= LO;
                    end
                end
                LO: begin
                    rsp_d[NW-1:0] <= sum[NW-1:0];
                    carry_lo      <= sum[NW];
                    state         <= HI;
                end
                HI: begin
                    rsp_d[DW-1:NW] <= sum[NW-1:0];
                    rsp_cout       <= sum[NW];
                    rsp_valid      <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arith_scheduler.sv
// Directed bench for arith_scheduler: arithmetic vectors, latency, back-pressure,
// arbitration (round-robin and fixed-priority instances) and mid-operation reset.
module tb_arith_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [1:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_ready;

    logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, busy;
    logic [7:0] rsp_d;
    logic       fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id, fp_rsp_cout, fp_busy;
    logic [7:0] fp_rsp_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arith_scheduler #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_d(rsp_d), .rsp_cout(rsp_cout), .busy(busy)
    );

    arith_scheduler #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id),
        .rsp_d(fp_rsp_d), .rsp_cout(fp_rsp_cout), .busy(fp_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one operation from IDLE; caller is positioned #1 after a rising edge.
    task automatic do_op(input bit id, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp_d, input bit exp_c);
        int cyc;
        rsp_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        #1;
        chk("ready_granted", id ? req1_ready : req0_ready, 1);
        chk("ready_other",   id ? req0_ready : req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b;
        req0_op = ~op; req1_op = ~op;
        chk("busy_lo", busy, 1);
        chk("ready_lo", {req0_ready, req1_ready}, 0);
        @(posedge clk); #1;
        chk("valid_early", rsp_valid, 0);
        cyc = 0;
        while (!rsp_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, 1);
        chk("rsp_d", rsp_d, exp_d);
        chk("rsp_cout", rsp_cout, exp_c);
        chk("rsp_id", rsp_id, id);
        @(posedge clk); #1;
        chk("valid_drop", rsp_valid, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        logic [7:0] hold_d;
        logic       hold_id;
        logic [3:0] rr_ids;
        logic [3:0] fp_ids;
        int n_rr;
        int n_fp;
        int cyc;

        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = '0; req1_op = '0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b1;
        #12;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_d", rsp_d, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_ready", {req0_ready, req1_ready}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Arithmetic vectors
        do_op(1'b0, 2'b00, 8'h4A, 8'h3C, 8'h86, 1'b0);
        do_op(1'b1, 2'b01, 8'h20, 8'h21, 8'hFF, 1'b0);
        do_op(1'b1, 2'b01, 8'h21, 8'h20, 8'h01, 1'b1);
        do_op(1'b0, 2'b10, 8'hFF, 8'h55, 8'h00, 1'b1);
        do_op(1'b0, 2'b11, 8'h00, 8'hAA, 8'hFF, 1'b0);
        do_op(1'b1, 2'b11, 8'h10, 8'h00, 8'h0F, 1'b1);
        do_op(1'b0, 2'b00, 8'hFF, 8'h01, 8'h00, 1'b1);

        // Back-pressure: hold RESP five cycles with requests pending
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 2'b00; req1_a = 8'h12; req1_b = 8'h34;
        @(posedge clk); #1;
        req1_a = 8'h99;
        cyc = 0;
        while (!rsp_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("bp_latency", cyc, 2);
        hold_d = rsp_d; hold_id = rsp_id;
        chk("bp_d", hold_d, 8'h46);
        chk("bp_id", hold_id, 1);
        req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_d_hold", rsp_d, 8'h46);
            chk("bp_id_hold", rsp_id, 1);
            chk("bp_readys", {req0_ready, req1_ready}, 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", rsp_valid, 0);
        chk("bp_idle", busy, 0);

        // Mid-operation reset during HI
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'h11; req0_b = 8'h22;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", rsp_valid, 0);
        chk("mrst_d", rsp_d, 8'h00);
        chk("mrst_busy", busy, 0);
        chk("mrst_cout", rsp_cout, 0);
        chk("mrst_id", rsp_id, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) cyc++;
        end
        chk("mrst_no_rsp", cyc, 0);
        do_op(1'b1, 2'b00, 8'h0F, 8'h01, 8'h10, 1'b0);

        // Arbitration with both requesters valid from reset
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'h01; req0_b = 8'h01;
        req1_valid = 1'b1; req1_op = 2'b00; req1_a = 8'h10; req1_b = 8'h10;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc = 0;
        while (!rsp_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("first_accept", cyc, 3);
        rr_ids = '0; fp_ids = '0;
        n_rr = 0; n_fp = 0;
        cyc = 0;
        while ((n_rr < 4 || n_fp < 4) && cyc < 40) begin
            if (rsp_valid && n_rr < 4) begin
                rr_ids[n_rr] = rsp_id;
                chk("rr_d", rsp_d, rsp_id ? 8'h20 : 8'h02);
                n_rr++;
            end
            if (fp_rsp_valid && n_fp < 4) begin
                fp_ids[n_fp] = fp_rsp_id;
                n_fp++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("rr_count", n_rr, 4);
        chk("rr_order", rr_ids, 4'b1010);
        chk("fp_count", n_fp, 4);
        chk("fp_order", fp_ids, 4'b0000);
        req0_valid = 1'b0; req1_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arith_scheduler.md
ARITH_SCHEDULER -- requirements
Module: arith_scheduler

Interface
REQ-001 Parameter: RR_EN, default 1, 1 = round-robin arbitration, 0 = fixed priority with req0 always winning.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_op  input  2  requester 0 opcode: 00 ADD, 01 SUB, 10 INC, 11 DEC.
REQ-007 req0_a, req0_b  input  8 each  requester 0 operands (b ignored for INC/DEC).
REQ-008 req1_valid, req1_ready, req1_op, req1_a, req1_b  same widths/meaning for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_id  output  1  index of requester that issued the result.
REQ-012 rsp_d  output  8  result; rsp_cout  output  1  carry out of bit 7.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 One shared 4-bit slice SHALL compute D = A + Y + CIN (mod 16, carry out of bit 3), with Y chosen by sel[1:0]: 00 B, 01 ~B, 10 0000, 11 1111.
REQ-015 Opcode mapping to slice controls SHALL be: ADD sel 00 cin 0; SUB sel 01 cin 1; INC sel 10 cin 1; DEC sel 11 cin 0.
REQ-016 Each 8-bit operation SHALL use the slice twice: low nibble with the opcode cin, then high nibble with cin = registered low-nibble carry; rsp_cout = high-nibble carry.
REQ-017 cout semantics: ADD carry; SUB 1 iff a >= b (no borrow); INC 1 iff a = 0xFF; DEC 1 iff a != 0x00.
REQ-018 FSM states SHALL be IDLE, LO, HI, RESP.
REQ-019 IDLE: if any reqN_valid, assert reqN_ready for exactly the granted requester (combinational from valid and state), capture op/a/b/id, go to LO; else stay.
REQ-020 reqN_ready SHALL be 0 in every state except IDLE and never high for both requesters.
REQ-021 LO: register low result nibble and carry, go to HI; HI: register high nibble and cout, go to RESP.
REQ-022 RESP: rsp_valid = 1 with rsp_id/rsp_d/rsp_cout stable until the cycle rsp_ready = 1, then go to IDLE.
REQ-023 Latency: acceptance at edge t -> rsp_valid high after edge t+2; no acceptance in the RESP->IDLE cycle; minimum 4 cycles per operation.
REQ-024 Round-robin (RR_EN=1): last_grant register; when both valid, grant requester != last_grant; single valid wins regardless; last_grant updates only on acceptance.
REQ-025 Fixed priority (RR_EN=0): req0 wins whenever req0_valid = 1.
REQ-026 Input operands SHALL be ignored after acceptance; changes to req lines during LO/HI/RESP SHALL not affect the in-flight result.
REQ-027 rsp_valid SHALL stay asserted under back-pressure indefinitely with no new acceptance.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, rsp_valid 0, rsp_d 0x00, rsp_cout 0, rsp_id 0, busy 0, req0_ready 0, req1_ready 0, last_grant 1 (req0 wins first contest).
REQ-029 Reset mid-operation SHALL discard the in-flight operation; no response is ever produced for it.
REQ-030 After rst_n deasserts, the first acceptance SHALL be possible on the first rising edge.

Verification
REQ-031 req0 ADD a=0x4A b=0x3C, rsp_ready=1 -> rsp_valid after 2 edges past acceptance, rsp_d=0x86, rsp_cout=0, rsp_id=0.
REQ-032 req1 SUB a=0x20 b=0x21 -> rsp_d=0xFF, rsp_cout=0, rsp_id=1; SUB 0x21-0x20 -> 0x01, cout 1.
REQ-033 INC a=0xFF -> rsp_d=0x00, cout 1; DEC a=0x00 -> rsp_d=0xFF, cout 0; DEC a=0x10 -> 0x0F, cout 1 (checks nibble carry chain).
REQ-034 Both valid continuously from reset, RR_EN=1 -> grants alternate 0,1,0,1; RR_EN=0 -> grants 0,0,0.
REQ-035 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rsp_d/rsp_id stable, both readys 0, then one-cycle handshake returns to IDLE.
REQ-036 rst_n pulsed low during HI -> outputs at reset values immediately, no rsp_valid afterward, next request completes normally.
